// File: rtl/router_req_resp.sv
`default_nettype none
// ============================================================================
// Module      : router_req_resp
// Description : Request/acknowledge burst router. On an accepted request it
//               reads BURST_LEN words from a source lane and writes them to a
//               destination lane through a one-word pipeline register, then
//               pulses router_ack and holds router_busy until the request is
//               released. Identical source and destination lanes complete
//               immediately with router_err.
// Revision    : 1.0 - initial release
// ============================================================================
module router_req_resp #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              router_start_req,
    input  logic [9:0]        router_scr_addr,
    input  logic [9:0]        router_dst_addr,
    input  logic [1:0]        router_src_dfx,
    input  logic [1:0]        router_dst_dfx,
    output logic              router_ack,
    output logic              router_err,
    output logic              router_busy,
    output logic              rd_en,
    output logic [9:0]        rd_addr,
    output logic [1:0]        rd_lane,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [9:0]        wr_addr,
    output logic [1:0]        wr_lane,
    output logic [DATA_W-1:0] wr_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        DRAIN    = 3'd2,
        ACK      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [7:0] c_burst_len = 8'(BURST_LEN);

    state_t              state_q,   state_d;
    logic [9:0]          src_q,     src_d;
    logic [9:0]          dst_q,     dst_d;
    logic [1:0]          src_dfx_q, src_dfx_d;
    logic [1:0]          dst_dfx_q, dst_dfx_d;
    logic [7:0]          rd_cnt_q,  rd_cnt_d;
    logic [7:0]          wr_cnt_q,  wr_cnt_d;
    logic                rd_vld_q,  rd_vld_d;
    logic                rd_en_q,   rd_en_d;
    logic [9:0]          rd_addr_q, rd_addr_d;
    logic [1:0]          rd_lane_q, rd_lane_d;
    logic                wr_en_q,   wr_en_d;
    logic [9:0]          wr_addr_q, wr_addr_d;
    logic [1:0]          wr_lane_q, wr_lane_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                ack_q,     ack_d;
    logic                err_q,     err_d;
    logic                busy_q,    busy_d;

    // Next-state and registered-output logic. The read-to-write pipeline runs
    // independently of the FSM: rd_vld marks the cycle in which rd_data holds
    // the word for the previous cycle's read, and that word is captured
    // straight into the write-data register so wr_en trails rd_en by two.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        src_dfx_d = src_dfx_q;
        dst_dfx_d = dst_dfx_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rd_vld_d  = rd_en_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_lane_d = rd_lane_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_lane_d = wr_lane_q;
        wr_data_d = wr_data_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;

        if (rd_vld_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q + {2'b00, wr_cnt_q};
            wr_lane_d = dst_dfx_q;
            wr_data_d = rd_data;
            wr_cnt_d  = wr_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (router_start_req) begin
                    src_d     = router_scr_addr;
                    dst_d     = router_dst_addr;
                    src_dfx_d = router_src_dfx;
                    dst_dfx_d = router_dst_dfx;
                    busy_d    = 1'b1;
                    if (router_src_dfx == router_dst_dfx) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = router_scr_addr;
                        rd_lane_d = router_src_dfx;
                        rd_cnt_d  = 8'd1;
                        wr_cnt_d  = 8'd0;
                        state_d   = READ;
                    end
                end
            end
            READ: begin
                if (rd_cnt_q != c_burst_len) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 10'd1;
                    rd_cnt_d  = rd_cnt_q + 8'd1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last write is on the bus now; acknowledge in the next cycle.
                if (wr_en_q && (wr_cnt_q == c_burst_len)) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!router_start_req) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            src_dfx_q <= '0;
            dst_dfx_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_lane_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_lane_q <= '0;
            wr_data_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            src_dfx_q <= src_dfx_d;
            dst_dfx_q <= dst_dfx_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_lane_q <= rd_lane_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_lane_q <= wr_lane_d;
            wr_data_q <= wr_data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign router_ack  = ack_q;
    assign router_err  = err_q;
    assign router_busy = busy_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign rd_lane     = rd_lane_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_lane     = wr_lane_q;
    assign wr_data     = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_router_req_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_req_resp
// Description : Scoreboard bench for router_req_resp. Each request pushes the
//               expected reads, writes and ack (with the cycle each must
//               appear in) into queues; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_req_resp;

    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              router_start_req;
    logic [9:0]        router_scr_addr;
    logic [9:0]        router_dst_addr;
    logic [1:0]        router_src_dfx;
    logic [1:0]        router_dst_dfx;
    logic              router_ack;
    logic              router_err;
    logic              router_busy;
    logic              rd_en;
    logic [9:0]        rd_addr;
    logic [1:0]        rd_lane;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic [1:0]        wr_lane;
    logic [DATA_W-1:0] wr_data;

    router_req_resp #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .router_start_req (router_start_req),
        .router_scr_addr  (router_scr_addr),
        .router_dst_addr  (router_dst_addr),
        .router_src_dfx   (router_src_dfx),
        .router_dst_dfx   (router_dst_dfx),
        .router_ack       (router_ack),
        .router_err       (router_err),
        .router_busy      (router_busy),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_lane          (rd_lane),
        .rd_data          (rd_data),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_lane          (wr_lane),
        .wr_data          (wr_data)
    );

    always #5 clk = ~clk;

    // Cycle label: the cycle following the k-th rising edge is cycle k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: word at address a reads as mem_base + a, one cycle after
    // the strobe; junk whenever no read was issued.
    logic [DATA_W-1:0] mem_base = '0;
    always @(posedge clk) rd_data <= rd_en ? (mem_base + 32'(rd_addr)) : 32'($urandom());

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [1:0]  lane;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t rdq[$];
    ev_t wrq[$];
    ev_t akq[$];

    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt     = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: compare every strobe against the scoreboard front entry and
    // flag any expected event whose cycle has passed without it appearing.
    ev_t mev;
    always @(negedge clk) begin
        if (rd_en) begin
            if (rdq.size() == 0) chk("rd_unexpected", 64'(rd_en), 64'(0));
            else begin
                mev = rdq.pop_front();
                chk("rd_cycle", 64'(cyc), 64'(mev.cyc));
                chk("rd_addr", 64'(rd_addr), 64'(mev.addr));
                chk("rd_lane", 64'(rd_lane), 64'(mev.lane));
            end
        end else if (rdq.size() != 0 && rdq[0].cyc <= cyc) begin
            mev = rdq.pop_front();
            chk("rd_missing", 64'(rd_en), 64'(1));
        end

        if (wr_en) begin
            if (wrq.size() == 0) chk("wr_unexpected", 64'(wr_en), 64'(0));
            else begin
                mev = wrq.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(mev.cyc));
                chk("wr_addr", 64'(wr_addr), 64'(mev.addr));
                chk("wr_lane", 64'(wr_lane), 64'(mev.lane));
                chk("wr_data", 64'(wr_data), 64'(mev.data));
            end
        end else if (wrq.size() != 0 && wrq[0].cyc <= cyc) begin
            mev = wrq.pop_front();
            chk("wr_missing", 64'(wr_en), 64'(1));
        end

        if (router_ack) begin
            ack_cnt <= ack_cnt + 1;
            if (akq.size() == 0) chk("ack_unexpected", 64'(router_ack), 64'(0));
            else begin
                mev = akq.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(mev.cyc));
                chk("ack_err", 64'(router_err), 64'(mev.err));
            end
        end else begin
            if (router_err) chk("err_without_ack", 64'(router_err), 64'(0));
            if (akq.size() != 0 && akq[0].cyc <= cyc) begin
                mev = akq.pop_front();
                chk("ack_missing", 64'(router_ack), 64'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] out_vec();
        return {router_ack, router_err, router_busy, rd_en, wr_en,
                rd_addr, wr_addr, rd_lane, wr_lane, wr_data};
    endfunction

    function automatic void flush();
        rdq.delete();
        wrq.delete();
        akq.delete();
    endfunction

    // Reference model: an accept at the coming edge (cycle k0 follows it)
    // yields reads in k0..k0+B-1, writes two cycles later carrying the word
    // at the matching source address, and ack right after the last write.
    task automatic push_req(input logic [9:0] s, input logic [9:0] d,
                            input logic [1:0] sd, input logic [1:0] dd);
        int k0;
        k0 = cyc + 1;
        if (sd == dd) begin
            akq.push_back('{cyc: k0, addr: 10'd0, lane: 2'd0, data: 32'd0, err: 1'b1});
        end else begin
            for (int i = 0; i < BURST_LEN; i++) begin
                rdq.push_back('{cyc: k0 + i, addr: 10'(s + i), lane: sd, data: 32'd0, err: 1'b0});
                wrq.push_back('{cyc: k0 + i + 2, addr: 10'(d + i), lane: dd,
                                data: mem_base + 32'(10'(s + i)), err: 1'b0});
            end
            akq.push_back('{cyc: k0 + BURST_LEN + 2, addr: 10'd0, lane: 2'd0, data: 32'd0, err: 1'b0});
        end
    endtask

    task automatic scramble_fields();
        router_scr_addr = 10'($urandom());
        router_dst_addr = 10'($urandom());
        router_src_dfx  = 2'($urandom());
        router_dst_dfx  = 2'($urandom());
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        router_start_req = 1'b0;
        flush();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait for the ack, hold the request for 'hold' more cycles, then release
    // and confirm busy falls in the cycle after the release is sampled.
    task automatic wait_ack_release(input int start_acks, input int hold, input bit scr);
        int n;
        n = 0;
        tick();
        while (ack_cnt == start_acks && n < BURST_LEN + 20) begin
            if (scr) scramble_fields();
            tick();
            n++;
        end
        if (ack_cnt == start_acks) begin
            chk("ack_timeout", 64'(ack_cnt - start_acks), 64'(1));
            hard_reset();
            return;
        end
        repeat (hold) begin
            if (scr) scramble_fields();
            tick();
        end
        chk("ack_count", 64'(ack_cnt - start_acks), 64'(1));
        chk("busy_held", 64'(router_busy), 64'(1));
        router_start_req = 1'b0;
        tick();
        chk("busy_released", 64'(router_busy), 64'(0));
    endtask

    task automatic do_xfer(input logic [9:0] s, input logic [9:0] d,
                           input logic [1:0] sd, input logic [1:0] dd,
                           input logic [31:0] base, input int hold, input bit scr);
        mem_base         = base;
        router_scr_addr  = s;
        router_dst_addr  = d;
        router_src_dfx   = sd;
        router_dst_dfx   = dd;
        router_start_req = 1'b1;
        push_req(s, d, sd, dd);
        wait_ack_release(ack_cnt, hold, scr);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            scramble_fields();
            tick();
            chk("idle_quiet", 64'({router_busy, rd_en, wr_en, router_ack}), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        router_start_req = 1'b0;
        router_scr_addr  = '0;
        router_dst_addr  = '0;
        router_src_dfx   = '0;
        router_dst_dfx   = '0;
        #3;
        chk("reset_outputs", out_vec(), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", out_vec(), 64'(0));

        // Basic burst: reads 1..4 on lane 1, writes 5..8 on lane 2, 0xA1..0xA4.
        do_xfer(10'h001, 10'h005, 2'd1, 2'd2, 32'hA0, 2, 1'b0);
        idle_cycles(3);

        // Same lane: immediate ack with error, no strobes.
        do_xfer(10'h123, 10'h234, 2'd3, 2'd3, 32'h0, 1, 1'b0);
        idle_cycles(2);

        // Address wrap on both sides.
        do_xfer(10'h3FE, 10'h3FF, 2'd0, 2'd1, 32'h5500_0000, 1, 1'b0);

        // Request held high for 50 cycles after ack: no second burst.
        do_xfer(10'h040, 10'h080, 2'd2, 2'd0, 32'h1234_0000, 50, 1'b1);
        idle_cycles(2);

        // Reset during the second read cycle with request held high.
        mem_base         = 32'hBEEF_0000;
        router_scr_addr  = 10'h100;
        router_dst_addr  = 10'h200;
        router_src_dfx   = 2'd1;
        router_dst_dfx   = 2'd3;
        router_start_req = 1'b1;
        push_req(10'h100, 10'h200, 2'd1, 2'd3);
        tick();
        tick();
        rst_n = 1'b0;
        flush();
        #1;
        chk("mid_reset_outputs", out_vec(), 64'(0));
        tick();
        chk("mid_reset_hold", out_vec(), 64'(0));
        rst_n = 1'b1;
        push_req(10'h100, 10'h200, 2'd1, 2'd3);
        wait_ack_release(ack_cnt, 3, 1'b0);

        // Release and re-assert with new fields.
        do_xfer(10'h010, 10'h020, 2'd0, 2'd2, 32'h7700_0000, 0, 1'b0);

        // Randomized transfers with mid-transfer field scrambling.
        for (int t = 0; t < 30; t++) begin
            logic [1:0] sd, dd;
            sd = 2'($urandom_range(0, 3));
            dd = ($urandom_range(0, 3) == 0) ? sd : 2'($urandom_range(0, 3));
            do_xfer(10'($urandom()), 10'($urandom()), sd, dd, 32'($urandom()),
                    int'($urandom_range(0, 4)), 1'b1);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        repeat (5) tick();
        chk("pending_rd", 64'(rdq.size()), 64'(0));
        chk("pending_wr", 64'(wrq.size()), 64'(0));
        chk("pending_ack", 64'(akq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
